// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32M encodings, FSM states and helpers
// for the multi-cycle M-extension execute unit.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MUL      = 3'd1;
  localparam logic [2:0] ST_DIV_ITER = 3'd2;
  localparam logic [2:0] ST_FIX      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  function automatic logic [63:0] min_int(input int xlen);
    min_int = 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: iterative restoring divider on unsigned magnitudes,
// one quotient bit per cycle, MSB first.
module mdu_div_core
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            last,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_TOP = CW'(XLEN - 1);

  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] d;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // diff[XLEN] set means the trial subtraction underflowed
  assign shifted = {r, q[XLEN-1]};
  assign diff    = shifted - {1'b0, d};
  assign last    = busy & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      q    <= '0;
      r    <= '0;
      d    <= '0;
      cnt  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
      cnt  <= CNT_TOP;
    end else if (busy) begin
      q   <= {q[XLEN-2:0], ~diff[XLEN]};
      r   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle RV32M execute unit beside the EX ALU;
// pipelined multiplier plus iterative divider, stalls until done.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [2:0]      func3,
  input  logic            flush,
  output logic            ready,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [63:0]     MIN64   = min_int(XLEN);
  localparam logic [XLEN-1:0] MIN_X   = MIN64[XLEN-1:0];
  localparam logic [7:0]      MUL_TOP = 8'(MUL_STAGES - 1);

  logic [2:0]      state;
  logic [7:0]      mul_cnt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] op1_q;
  logic            dz_q;
  logic            ovf_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            accept;

  assign ready  = (state == ST_IDLE);
  assign done   = (state == ST_DONE);
  assign stall  = valid_in & ~done;
  assign accept = valid_in & ready & ~flush;

  // product is formed from the raw inputs in the accept cycle
  logic                   sa;
  logic                   sb;
  logic signed [XLEN:0]   ma;
  logic signed [XLEN:0]   mb;
  logic signed [2*XLEN+1:0] prod;
  logic [1:0]             unused_prod_hi;
  logic [2*XLEN-1:0]      pipe [MUL_STAGES];

  assign sa   = (func3 == F3_MULH) | (func3 == F3_MULHSU);
  assign sb   = (func3 == F3_MULH);
  assign ma   = {sa & op1[XLEN-1], op1};
  assign mb   = {sb & op2[XLEN-1], op2};
  assign prod = ma * mb;
  assign unused_prod_hi = prod[2*XLEN+1:2*XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= prod[2*XLEN-1:0];
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic            sdiv;
  logic            n1;
  logic            n2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_busy;
  logic            div_last;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;

  assign sdiv = ~func3[0];
  assign n1   = sdiv & op1[XLEN-1];
  assign n2   = sdiv & op2[XLEN-1];
  assign abs1 = n1 ? -op1 : op1;
  assign abs2 = n2 ? -op2 : op2;

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept & func3[2]),
    .abort     (flush),
    .dividend  (abs1),
    .divisor   (abs2),
    .busy      (div_busy),
    .last      (div_last),
    .quotient  (quot),
    .remainder (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q   <= '0;
      op1_q  <= '0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      f3_q   <= func3;
      op1_q  <= op1;
      dz_q   <= (op2 == '0);
      ovf_q  <= sdiv & (op1 == MIN_X) & (op2 == '1);
      qneg_q <= n1 ^ n2;
      rneg_q <= n1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
    end else if (flush && state != ST_IDLE) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state   <= func3[2] ? ST_DIV_ITER : ST_MUL;
          mul_cnt <= MUL_TOP;
        end
        ST_MUL: begin
          if (mul_cnt == '0) state <= ST_DONE;
          else mul_cnt <= mul_cnt - 1'b1;
        end
        ST_DIV_ITER: if (!div_busy || div_last) state <= ST_FIX;
        ST_FIX:  state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [XLEN-1:0] mul_val;
  logic [XLEN-1:0] qfix;
  logic [XLEN-1:0] rfix;
  logic [XLEN-1:0] div_val;
  logic [2*XLEN-1:0] mul_full;

  assign mul_full = pipe[MUL_STAGES-1];
  assign mul_val  = (f3_q[1:0] == 2'b00) ? mul_full[XLEN-1:0]
                                         : mul_full[2*XLEN-1:XLEN];
  assign qfix = qneg_q ? -quot : quot;
  assign rfix = rneg_q ? -rem : rem;

  always_comb begin
    div_val = qfix;
    if (f3_q[1]) div_val = dz_q ? op1_q : (ovf_q ? '0 : rfix);
    else         div_val = dz_q ? '1 : (ovf_q ? MIN_X : qfix);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (!flush) begin
      if (state == ST_MUL && mul_cnt == '0) result <= mul_val;
      else if (state == ST_FIX)             result <= div_val;
    end
  end

endmodule
